// File: rtl/hmmm_fsm_controller.sv
// hmmm_fsm_controller
// Multicycle sequencer for the 8-bit HMMM-style datapath. Each instruction takes
// FETCH -> DECODE -> EXEC (three cycles). All datapath selects and strobes decode
// from the registered state, plus the opcode while in EXEC. The block also
// provides run/step gating, a halt state, an illegal-opcode fault state and a
// retired-instruction counter.
module hmmm_fsm_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic [7:0]       cond_val,
    output logic             PCEnable,
    output logic             AdrSrc,
    output logic             InstrSrc,
    output logic             RegWrite,
    output logic             TwoRegs,
    output logic             ALUSub,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegWriteSrc,
    output logic             MemWrite,
    output logic             halted,
    output logic             fault,
    output logic             retired,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_HALTED = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic cond_zero;
    logic cond_neg;

    assign cond_zero = ~|cond_val;
    assign cond_neg  = cond_val[7];

    // State register; reset aborts any instruction in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // Retired-instruction counter: one increment per EXEC cycle, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 instr_cnt <= '0;
        else if (state == S_EXEC)  instr_cnt <= instr_cnt + CNT_W'(1);
    end

    // Next-state and output decode from state (and op/cond_val in EXEC).
    always_comb begin
        state_nx    = S_FETCH;
        PCEnable    = 1'b0;
        AdrSrc      = 1'b0;
        InstrSrc    = 1'b0;
        RegWrite    = 1'b0;
        TwoRegs     = 1'b0;
        ALUSub      = 1'b0;
        PCSrc       = 2'b00;
        RegWriteSrc = 2'b00;
        MemWrite    = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        retired     = 1'b0;

        case (state)
            S_FETCH: begin
                InstrSrc = 1'b1;
                state_nx = run ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                PCEnable = 1'b1;
                PCSrc    = 2'b00;
                if (op == 4'b0000)      state_nx = S_HALTED;
                else if (op == 4'b1111) state_nx = S_FAULT;
                else                    state_nx = S_EXEC;
            end

            S_EXEC: begin
                retired  = 1'b1;
                state_nx = S_FETCH;
                case (op)
                    4'b0001: begin
                        RegWrite    = 1'b1;
                        RegWriteSrc = 2'b00;
                    end
                    4'b0010: begin
                        AdrSrc      = 1'b1;
                        RegWrite    = 1'b1;
                        RegWriteSrc = 2'b01;
                    end
                    4'b0011: begin
                        AdrSrc   = 1'b1;
                        MemWrite = 1'b1;
                    end
                    4'b0100, 4'b0101: begin
                        RegWrite    = 1'b1;
                        RegWriteSrc = 2'b10;
                        TwoRegs     = 1'b0;
                        ALUSub      = op[0];
                    end
                    4'b0110, 4'b0111: begin
                        RegWrite    = 1'b1;
                        RegWriteSrc = 2'b10;
                        TwoRegs     = 1'b1;
                        ALUSub      = op[0];
                    end
                    4'b1000: begin
                        PCEnable = 1'b1;
                        PCSrc    = 2'b01;
                    end
                    4'b1001: begin
                        PCEnable = 1'b1;
                        PCSrc    = 2'b10;
                    end
                    4'b1010: begin
                        PCSrc    = 2'b01;
                        PCEnable = cond_zero;
                    end
                    4'b1011: begin
                        PCSrc    = 2'b01;
                        PCEnable = ~cond_zero;
                    end
                    4'b1100: begin
                        PCSrc    = 2'b01;
                        PCEnable = ~cond_neg & ~cond_zero;
                    end
                    4'b1101: begin
                        PCSrc    = 2'b01;
                        PCEnable = cond_neg;
                    end
                    default: begin
                        // NOP, plus HALT/illegal codes that DECODE never lets reach here
                    end
                endcase
            end

            S_HALTED: begin
                halted   = 1'b1;
                state_nx = S_HALTED;
            end

            S_FAULT: begin
                fault    = 1'b1;
                state_nx = S_FAULT;
            end

            default: begin
                state_nx = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_hmmm_fsm_controller.sv
// tb_hmmm_fsm_controller
// Randomized and directed stimulus against an instruction-level reference model.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_hmmm_fsm_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] op;
    logic [7:0] cond_val;

    logic        PCEnable, AdrSrc, InstrSrc, RegWrite, TwoRegs, ALUSub, MemWrite;
    logic        halted, fault, retired;
    logic [1:0]  PCSrc, RegWriteSrc;
    logic [15:0] instr_cnt;

    logic        b_PCEnable, b_AdrSrc, b_InstrSrc, b_RegWrite, b_TwoRegs, b_ALUSub, b_MemWrite;
    logic        b_halted, b_fault, b_retired;
    logic [1:0]  b_PCSrc, b_RegWriteSrc;
    logic [3:0]  b_instr_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: instruction phase (0 fetch, 1 decode, 2 exec, 3 halted, 4 fault)
    // and the number of retired instructions since reset.
    int          phase = 0;
    int unsigned mcnt  = 0;

    hmmm_fsm_controller #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .op(op), .cond_val(cond_val),
        .PCEnable(PCEnable), .AdrSrc(AdrSrc), .InstrSrc(InstrSrc), .RegWrite(RegWrite),
        .TwoRegs(TwoRegs), .ALUSub(ALUSub), .PCSrc(PCSrc), .RegWriteSrc(RegWriteSrc),
        .MemWrite(MemWrite), .halted(halted), .fault(fault), .retired(retired),
        .instr_cnt(instr_cnt)
    );

    hmmm_fsm_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .op(op), .cond_val(cond_val),
        .PCEnable(b_PCEnable), .AdrSrc(b_AdrSrc), .InstrSrc(b_InstrSrc), .RegWrite(b_RegWrite),
        .TwoRegs(b_TwoRegs), .ALUSub(b_ALUSub), .PCSrc(b_PCSrc), .RegWriteSrc(b_RegWriteSrc),
        .MemWrite(b_MemWrite), .halted(b_halted), .fault(b_fault), .retired(b_retired),
        .instr_cnt(b_instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control bundle, in a fixed field order.
    function automatic logic [13:0] act();
        return {PCEnable, AdrSrc, InstrSrc, RegWrite, TwoRegs, ALUSub,
                PCSrc, RegWriteSrc, MemWrite, halted, fault, retired};
    endfunction

    // Expected control bundle from the instruction semantics.
    function automatic logic [13:0] model_out(int ph, logic [3:0] o, logic [7:0] c);
        logic pce, adr, isrc, rw, two, sub, mw, h, f, ret;
        logic [1:0] pcs, rws;
        logic signed [7:0] sc;
        pce = 0; adr = 0; isrc = 0; rw = 0; two = 0; sub = 0; mw = 0;
        h = 0; f = 0; ret = 0; pcs = 2'd0; rws = 2'd0;
        sc = c;
        case (ph)
            0: isrc = 1;
            1: pce = 1;
            2: begin
                ret = 1;
                case (o)
                    4'd1:  begin rw = 1; rws = 2'd0; end
                    4'd2:  begin adr = 1; rw = 1; rws = 2'd1; end
                    4'd3:  begin adr = 1; mw = 1; end
                    4'd4:  begin rw = 1; rws = 2'd2; end
                    4'd5:  begin rw = 1; rws = 2'd2; sub = 1; end
                    4'd6:  begin rw = 1; rws = 2'd2; two = 1; end
                    4'd7:  begin rw = 1; rws = 2'd2; two = 1; sub = 1; end
                    4'd8:  begin pce = 1; pcs = 2'd1; end
                    4'd9:  begin pce = 1; pcs = 2'd2; end
                    4'd10: begin pcs = 2'd1; pce = (sc == 0); end
                    4'd11: begin pcs = 2'd1; pce = (sc != 0); end
                    4'd12: begin pcs = 2'd1; pce = (sc > 0); end
                    4'd13: begin pcs = 2'd1; pce = (sc < 0); end
                    default: ;
                endcase
            end
            3: h = 1;
            4: f = 1;
            default: ;
        endcase
        return {pce, adr, isrc, rw, two, sub, pcs, rws, mw, h, f, ret};
    endfunction

    // Advance one clock and move the model by the instruction rules.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            case (phase)
                0: if (run) phase = 1;
                1: phase = (op == 4'd0) ? 3 : (op == 4'd15) ? 4 : 2;
                2: begin mcnt++; phase = 0; end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        phase = 0;
        mcnt  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; op = 4'd1; cond_val = 8'h00;
        phase = 0; mcnt = 0;
        @(negedge clk);
        #1;
        checks++;
        if (act() !== 14'b00_1000_0000_0000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=%b", act(), 14'b00_1000_0000_0000);
        end
        checks++;
        if (instr_cnt !== 16'd0 || b_instr_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", instr_cnt, b_instr_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_setn();
        run = 1'b1; op = 4'd1; cond_val = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (act() !== model_out(phase, op, cond_val)) begin
                errors++; $display("FAIL setn_ctrl ph=%0d got=%b exp=%b", phase, act(), model_out(phase, op, cond_val));
            end
            tick();
        end
        #1;
        checks++;
        if (instr_cnt !== 16'(mcnt) || instr_cnt !== 16'd1) begin
            errors++; $display("FAIL setn_cnt got=%0d exp=1", instr_cnt);
        end
    endtask

    task automatic test_alu_store();
        logic [3:0] ops [6];
        ops = '{4'd7, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2};
        for (int k = 0; k < 6; k++) begin
            run = 1'b1; op = ops[k];
            for (int i = 0; i < 3; i++) begin
                cond_val = 8'($urandom);
                #1;
                checks++;
                if (act() !== model_out(phase, op, cond_val)) begin
                    errors++; $display("FAIL alu_store op=%0d ph=%0d got=%b exp=%b", op, phase, act(), model_out(phase, op, cond_val));
                end
                tick();
            end
            checks++;
            if (instr_cnt !== 16'(mcnt)) begin
                errors++; $display("FAIL alu_store_cnt got=%0d exp=%0d", instr_cnt, mcnt);
            end
        end
    endtask

    task automatic test_branches();
        logic [3:0] bops  [12];
        logic [7:0] bconds[12];
        bops   = '{4'd10, 4'd10, 4'd13, 4'd13, 4'd11, 4'd12, 4'd12, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13};
        bconds = '{8'h00, 8'h05, 8'h80, 8'h7F, 8'h00, 8'h01, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h00, 8'h00};
        for (int k = 0; k < 20; k++) begin
            run = 1'b1;
            if (k < 12) op = bops[k];
            else        op = 4'(8 + $urandom_range(0, 5));
            for (int i = 0; i < 3; i++) begin
                cond_val = (k < 12) ? bconds[k] : 8'($urandom);
                #1;
                checks++;
                if (act() !== model_out(phase, op, cond_val)) begin
                    errors++; $display("FAIL branch op=%0d cond=%h ph=%0d got=%b exp=%b", op, cond_val, phase, act(), model_out(phase, op, cond_val));
                end
                tick();
            end
        end
    endtask

    task automatic test_run_gating();
        logic [15:0] c0;
        run = 1'b0; op = 4'd6; cond_val = 8'h11;
        c0 = instr_cnt;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (act() !== model_out(phase, op, cond_val) || instr_cnt !== 16'(mcnt)) begin
                errors++; $display("FAIL run_hold got=%b cnt=%0d exp=%b cnt=%0d", act(), instr_cnt, model_out(phase, op, cond_val), mcnt);
            end
            tick();
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (act() !== model_out(phase, op, cond_val) || instr_cnt !== 16'(mcnt)) begin
                errors++; $display("FAIL run_step got=%b cnt=%0d exp=%b cnt=%0d", act(), instr_cnt, model_out(phase, op, cond_val), mcnt);
            end
            tick();
        end
        checks++;
        if (instr_cnt - c0 !== 16'd1) begin
            errors++; $display("FAIL run_step_delta got=%0d exp=1", instr_cnt - c0);
        end
    endtask

    task automatic test_reset_mid_exec();
        if (phase != 0) do_reset();
        run = 1'b1; op = 4'd3; cond_val = 8'h00;
        tick();
        tick();
        #1;
        checks++;
        if (MemWrite !== 1'b1 || AdrSrc !== 1'b1 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL store_exec got MemWrite=%b AdrSrc=%b RegWrite=%b exp 1 1 0", MemWrite, AdrSrc, RegWrite);
        end
        #1;
        reset = 1'b1;
        phase = 0;
        mcnt  = 0;
        #1;
        checks++;
        if (act() !== model_out(0, op, cond_val)) begin
            errors++; $display("FAIL async_reset_ctrl got=%b exp=%b", act(), model_out(0, op, cond_val));
        end
        checks++;
        if (instr_cnt !== 16'd0 || b_instr_cnt !== 4'd0) begin
            errors++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", instr_cnt, b_instr_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1; op = 4'd14;
        for (int i = 0; i < 48; i++) begin
            cond_val = 8'($urandom);
            #1;
            checks++;
            if (act() !== model_out(phase, op, cond_val) || instr_cnt !== 16'(mcnt) || b_instr_cnt !== 4'(mcnt)) begin
                errors++; $display("FAIL wrap got=%b cnt=%0d/%0d exp=%b cnt=%0d", act(), instr_cnt, b_instr_cnt, model_out(phase, op, cond_val), mcnt);
            end
            tick();
        end
        #1;
        checks++;
        if (b_instr_cnt !== 4'd0 || instr_cnt !== 16'd16) begin
            errors++; $display("FAIL wrap_end got=%0d/%0d exp=16/0", instr_cnt, b_instr_cnt);
        end
    endtask

    task automatic test_halt_fault();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            run = 1'b1; op = 4'd1;
            for (int i = 0; i < 3; i++) tick();
            op = (k == 0) ? 4'd0 : 4'd15;
            tick();
            tick();
            for (int i = 0; i < 20; i++) begin
                run = 1'($urandom); op = 4'($urandom); cond_val = 8'($urandom);
                #1;
                checks++;
                if (act() !== model_out(phase, op, cond_val) || instr_cnt !== 16'd1) begin
                    errors++; $display("FAIL halt_fault k=%0d got=%b cnt=%0d exp=%b cnt=1", k, act(), instr_cnt, model_out(phase, op, cond_val));
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (phase >= 3 && $urandom_range(0, 3) == 0) do_reset();
            run = ($urandom_range(0, 9) < 7);
            if (phase == 0) begin
                if ($urandom_range(0, 29) == 0) op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
                else                            op = 4'($urandom_range(1, 14));
            end
            cond_val = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            #1;
            checks++;
            if (act() !== model_out(phase, op, cond_val) || instr_cnt !== 16'(mcnt) || b_instr_cnt !== 4'(mcnt)) begin
                errors++; $display("FAIL random i=%0d op=%0d ph=%0d got=%b cnt=%0d/%0d exp=%b cnt=%0d", i, op, phase, act(), instr_cnt, b_instr_cnt, model_out(phase, op, cond_val), mcnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_setn();
        test_alu_store();
        test_branches();
        test_run_gating();
        test_reset_mid_exec();
        test_wrap();
        test_halt_fault();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
